ram_arbiter: RTL

Arbitrates the single-ported RAM between the instruction-fetch port (`iREN`) and the data port (`dREN`/`dWEN`) produced by the request unit. It sequences one RAM transaction at a time against a variable-latency RAM that reports `ramstate`. It returns `iwait`/`dwait` and the load data to each requester. It sits between the pipeline's request/cache side and the RAM model, and replaces direct wiring of the data and instruction enables onto the RAM.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/arb_timeout_counter.sv | 30 +++
 rtl/ram_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word, RAM status, arbiter FSM state and default timeout.
package cpu_types_pkg;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DGRANT = 2'b01,
      IGRANT = 2'b10
   } arb_state_t;

   localparam int ARB_TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/arb_timeout_counter.sv
// 8-bit saturating grant-cycle counter; expired is high on the LIMIT-th counted grant cycle.
module arb_timeout_counter #(
   parameter int LIMIT = 255
) (
   input  logic CLK,
   input  logic nRST,
   input  logic clear,
   input  logic count_en,
   output logic expired
);
   localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (count_en && cnt_q != 8'hFF)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Counter starts at 0 in the first grant cycle, so LIMIT-1 marks the LIMIT-th cycle.
   assign expired = !clear && (cnt_q >= LIMIT_M1);
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter of one single-ported RAM between instruction fetch and data port.
// Optional grant timeout under RAM_ARBITER_TIMEOUT_EN; one IDLE cycle between transactions.
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      memerr
);
   arb_state_t state_q, state_d;
   logic       last_d_q, last_d_d;
   logic       memerr_q;

   logic d_req, in_d, in_i, req_g;
   logic timeout_hit, ok_done, err_done, done;

   assign d_req = dREN | dWEN;
   assign in_d  = (state_q == DGRANT);
   assign in_i  = (state_q == IGRANT);
   assign req_g = (in_d & d_req) | (in_i & iREN);

`ifdef RAM_ARBITER_TIMEOUT_EN
   arb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .CLK      (CLK),
      .nRST     (nRST),
      .clear    (state_q == IDLE),
      .count_en ((in_d | in_i) && ramstate != ACCESS && ramstate != ERROR),
      .expired  (timeout_hit)
   );
`else
   logic timeout_unused;
   assign timeout_unused = ^TIMEOUT_CYCLES;
   assign timeout_hit    = 1'b0;
`endif

   // A real ACCESS in the expiring cycle still counts as a good completion.
   assign ok_done  = req_g & (ramstate == ACCESS);
   assign err_done = req_g & ((ramstate == ERROR) | (timeout_hit & (ramstate != ACCESS)));
   assign done     = ok_done | err_done;

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      case (state_q)
         IDLE: begin
            if (d_req && (!iREN || !last_d_q)) state_d = DGRANT;
            else if (iREN)                     state_d = IGRANT;
         end
         DGRANT, IGRANT: begin
            if (!req_g) begin
               state_d = IDLE;
            end else if (done) begin
               state_d  = IDLE;
               last_d_d = in_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         memerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         memerr_q <= err_done;
      end
   end

   assign ramREN   = in_d ? dREN   : (in_i ? iREN : 1'b0);
   assign ramWEN   = in_d & dWEN;
   assign ramaddr  = in_d ? daddr  : (in_i ? iaddr : '0);
   assign ramstore = in_d ? dstore : '0;

   assign iwait  = iREN  & ~(in_i & done);
   assign dwait  = d_req & ~(in_d & done);
   assign iload  = (in_i & ~err_done) ? ramload : '0;
   assign dload  = (in_d & ~err_done) ? ramload : '0;
   assign memerr = memerr_q;
endmodule
